// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed 32x32 radix-2 Booth multiplier driving a 32-bit CLA, one step per cycle.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the Booth loop and completes the cycle after start.
module booth_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [7:0]  bg, bp;
  logic [8:0]  gc;
  assign g = a & b;
  assign p = a ^ b;
  genvar k;
  for (k = 0; k < 8; k++) begin : grp
    logic [3:0] gg, pp, c;
    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign bg[k] = gg[3] | pp[3] & gg[2] | pp[3] & pp[2] & gg[1] | pp[3] & pp[2] & pp[1] & gg[0];
    assign bp[k] = &pp;
    assign c = {gg[2] | pp[2] & gg[1] | pp[2] & pp[1] & gg[0] | pp[2] & pp[1] & pp[0] & gc[k],
                gg[1] | pp[1] & gg[0] | pp[1] & pp[0] & gc[k],
                gg[0] | pp[0] & gc[k],
                gc[k]};
    assign sum[4*k +: 4] = pp ^ c;
  end
  always_comb begin
    gc[0] = cin;
    for (int i = 0; i < 8; i++) gc[i+1] = bg[i] | bp[i] & gc[i];
  end
  assign cout = gc[8];
endmodule

module booth_multiplier #(
  parameter int ITERATIONS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_n;
  logic [32:0] m, acc, m_op, acc_sum, acc_n;
  logic [31:0] q, sum;
  logic [5:0]  counter;
  logic        qm1, sub, add_en, cout, zero_op, step, finish, last;
`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = data_operandA == '0 || data_operandB == '0;
`else
  assign zero_op = 1'b0;
`endif
  assign last = counter == 6'(ITERATIONS - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = ctrl_MULT ? (zero_op ? DONE : RUN) : state == RUN ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    step = state == RUN && !ctrl_MULT;
    finish = state == DONE && !ctrl_MULT;
  end
  // The 33rd accumulator bit is formed outside the 32-bit adder from its carry-out.
  assign sub = q[0] & ~qm1;
  assign add_en = q[0] ^ qm1;
  assign m_op = sub ? ~m : m;
  booth_cla32 u_cla (.a(acc[31:0]), .b(m_op[31:0]), .cin(sub), .sum(sum), .cout(cout));
  assign acc_sum = {acc[32] ^ m_op[32] ^ cout, sum};
  assign acc_n = add_en ? acc_sum : acc;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      m <= '0;
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      counter <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      if (ctrl_MULT) begin
        m <= zero_op ? '0 : {data_operandA[31], data_operandA};
        acc <= '0;
        q <= zero_op ? '0 : data_operandB;
        qm1 <= 1'b0;
        counter <= '0;
      end else if (step) begin
        {acc, q, qm1} <= {acc_n[32], acc_n, q};
        counter <= counter + 6'd1;
      end
      data_resultRDY <= finish;
      if (finish) begin
        data_result <= q;
        data_exception <= ~(&{acc[31:0], q[31]} | ~|{acc[31:0], q[31]});
      end
    end
endmodule
